// File: rtl/sw_led_ctrl.sv
// Switch-to-LED controller: debounces switches, captures a pattern on a LOAD
// edge, and shows pass-through, hold, rotate or blink on the LEDs.
module sw_led_ctrl #(
  parameter int WIDTH       = 10,
  parameter int DB_CYCLES   = 4,
  parameter int TICK_CYCLES = 8
) (
  input  logic             CLOCK_50,
  input  logic             RST,
  input  logic [WIDTH-1:0] SW,
  input  logic [1:0]       MODE,
  input  logic             LOAD,
  output logic [WIDTH-1:0] LEDR,
  output logic             TICK
);

  localparam int DBW = $clog2(DB_CYCLES + 1);
  localparam int TW  = $clog2(TICK_CYCLES);
  localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES - 1);
  localparam logic [TW-1:0]  T_LAST  = TW'(TICK_CYCLES - 1);

  typedef enum logic [1:0] {
    M_PASS  = 2'd0,
    M_HOLD  = 2'd1,
    M_ROT   = 2'd2,
    M_BLINK = 2'd3
  } mode_e;

  mode_e              mode;
  mode_e              mode_q;
  logic [WIDTH-1:0]   db;
  logic [DBW-1:0]     db_cnt [WIDTH];
  logic [WIDTH-1:0]   pat;
  logic [WIDTH-1:0]   pat_nxt;
  logic [WIDTH-1:0]   led_nxt;
  logic [TW-1:0]      tcnt;
  logic [TW-1:0]      tcnt_nxt;
  logic               ph;
  logic               ph_nxt;
  logic               load_q;
  logic               load_edge;
  logic               mode_chg;
  logic               rot_mode;
  logic               wrap;

  assign mode = mode_e'(MODE);

  // A bit is accepted only once it has disagreed with DB for DB_CYCLES clocks.
  always_ff @(posedge CLOCK_50 or posedge RST) begin
    if (RST) begin
      db <= '0;
      for (int i = 0; i < WIDTH; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (SW[i] != db[i]) begin
          if (db_cnt[i] == DB_LAST) begin
            db[i]     <= SW[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + 1'b1;
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  // A mode change restarts the step counter, so no tick fires on that clock.
  always_comb begin
    load_edge = LOAD & ~load_q;
    mode_chg  = (mode != mode_q);
    rot_mode  = (mode == M_ROT) || (mode == M_BLINK);
    wrap      = rot_mode && !mode_chg && (tcnt == T_LAST);
    tcnt_nxt  = (!rot_mode || mode_chg || wrap) ? '0 : tcnt + 1'b1;

    pat_nxt = pat;
    if (load_edge)
      pat_nxt = db;
    else if (wrap && mode == M_ROT)
      pat_nxt = {pat[WIDTH-2:0], pat[WIDTH-1]};

    ph_nxt = ph;
    if (mode_chg)
      ph_nxt = 1'b1;
    else if (wrap && mode == M_BLINK)
      ph_nxt = ~ph;

    led_nxt = '0;
    case (mode)
      M_PASS:  led_nxt = db;
      M_HOLD:  led_nxt = pat_nxt;
      M_ROT:   led_nxt = pat_nxt;
      M_BLINK: led_nxt = ph_nxt ? pat_nxt : '0;
      default: led_nxt = '0;
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge RST) begin
    if (RST) begin
      mode_q <= M_PASS;
      load_q <= 1'b0;
      tcnt   <= '0;
      TICK   <= 1'b0;
      pat    <= '0;
      ph     <= 1'b1;
      LEDR   <= '0;
    end else begin
      mode_q <= mode;
      load_q <= LOAD;
      tcnt   <= tcnt_nxt;
      TICK   <= wrap;
      pat    <= pat_nxt;
      ph     <= ph_nxt;
      LEDR   <= led_nxt;
    end
  end

endmodule

// File: tb/tb_sw_led_ctrl.sv
// Directed self-checking bench for sw_led_ctrl at WIDTH=10, DB_CYCLES=4,
// TICK_CYCLES=8; inputs change and outputs are sampled 1 ns after a rising edge.
module tb_sw_led_ctrl;

  logic       clock_50 = 1'b0;
  logic       rst;
  logic [9:0] sw;
  logic [1:0] mode;
  logic       load;
  logic [9:0] ledr;
  logic       tick;

  int n_vec  = 0;
  int n_fail = 0;

  sw_led_ctrl #(.WIDTH(10), .DB_CYCLES(4), .TICK_CYCLES(8)) dut (
    .CLOCK_50(clock_50),
    .RST     (rst),
    .SW      (sw),
    .MODE    (mode),
    .LOAD    (load),
    .LEDR    (ledr),
    .TICK    (tick)
  );

  always #5 clock_50 = ~clock_50;

  task automatic step(input int n);
    repeat (n) @(posedge clock_50);
    #1;
  endtask

  task automatic check(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  initial begin
    rst  = 1'b1;
    sw   = '0;
    mode = 2'd0;
    load = 1'b0;
    #3;
    check("reset_ledr", ledr, 10'b0);
    check("reset_tick", {9'b0, tick}, 10'b0);
    step(2);
    rst = 1'b0;

    // short glitch on bit 0 must not pass the debouncer
    sw = 10'b0000000001;
    step(3);
    sw = 10'b0;
    step(6);
    check("glitch_ignored", ledr, 10'b0);

    // stable change reaches LEDR exactly on the fifth edge
    sw = 10'b0101110101;
    step(4);
    check("pass_edge4", ledr, 10'b0);
    step(1);
    check("pass_edge5", ledr, 10'b0101110101);

    // hold mode keeps the captured pattern regardless of switches
    sw = 10'b0001000010;
    step(6);
    check("pass_settled", ledr, 10'b0001000010);
    mode = 2'd1;
    step(1);
    check("hold_prior_pat", ledr, 10'b0);
    load = 1'b1;
    step(1);
    check("hold_loaded", ledr, 10'b0001000010);
    sw = 10'b1111111111;
    step(8);
    check("hold_ignores_sw", ledr, 10'b0001000010);

    // load a single-bit pattern and rotate it
    load = 1'b0;
    sw   = 10'b1000000000;
    step(6);
    load = 1'b1;
    step(1);
    check("hold_load2", ledr, 10'b1000000000);
    load = 1'b0;
    mode = 2'd2;
    step(1);
    check("rot_start_led", ledr, 10'b1000000000);
    check("rot_start_tick", {9'b0, tick}, 10'b0);
    step(7);
    check("rot_pre_tick", {9'b0, tick}, 10'b0);
    step(1);
    check("rot_tick1", {9'b0, tick}, 10'b1);
    check("rot_led1", ledr, 10'b0000000001);
    step(1);
    check("rot_tick_pulse", {9'b0, tick}, 10'b0);
    sw = 10'b0010101110;
    step(7);
    check("rot_tick2", {9'b0, tick}, 10'b1);
    check("rot_led2", ledr, 10'b0000000010);
    step(7);
    load = 1'b1;
    step(1);
    check("load_on_tick_tick", {9'b0, tick}, 10'b1);
    check("load_on_tick_led", ledr, 10'b0010101110);
    step(8);
    check("rot_after_load", ledr, 10'b0101011100);

    // blink mode alternates pattern and dark every tick
    sw   = 10'b0110111010;
    load = 1'b0;
    step(6);
    load = 1'b1;
    step(1);
    mode = 2'd3;
    step(1);
    check("blink_start_led", ledr, 10'b0110111010);
    check("blink_start_tick", {9'b0, tick}, 10'b0);
    step(8);
    check("blink_off", ledr, 10'b0);
    check("blink_tick", {9'b0, tick}, 10'b1);
    step(8);
    check("blink_on", ledr, 10'b0110111010);

    // switching mode mid-count restarts the tick counter
    step(3);
    mode = 2'd2;
    step(1);
    check("switch_led", ledr, 10'b0110111010);
    for (int i = 0; i < 7; i++) begin
      step(1);
      check("switch_no_tick", {9'b0, tick}, 10'b0);
    end
    step(1);
    check("switch_tick", {9'b0, tick}, 10'b1);
    check("switch_rot", ledr, 10'b1101110100);
    step(8);
    check("rot_again", ledr, 10'b1011101001);

    // asynchronous reset between edges, just after a tick
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_led", ledr, 10'b0);
    check("async_rst_tick", {9'b0, tick}, 10'b0);
    sw = 10'b1111111111;
    step(1);
    check("rst_held_led", ledr, 10'b0);
    rst = 1'b0;
    step(1);
    check("post_rst_load", ledr, 10'b0);
    mode = 2'd0;
    step(3);
    check("post_rst_db_edge4", ledr, 10'b0);
    step(1);
    check("post_rst_db_edge5", ledr, 10'b1111111111);
    mode = 2'd1;
    step(1);
    check("post_rst_pat", ledr, 10'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/sw_led_ctrl.md
SW_LED_CTRL -- requirements
Module: sw_led_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 10, giving the number of switch inputs and LED outputs; legal values are 2 to 32.
REQ-002 SHALL have parameter DB_CYCLES, default 4, giving the number of consecutive clocks a switch change must hold before it is accepted; minimum 1.
REQ-003 SHALL have parameter TICK_CYCLES, default 8, giving the clocks per rotate/blink step; minimum 2.
REQ-004 SHALL have port CLOCK_50, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port RST, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port SW, input, WIDTH bits: raw switch levels, asynchronous to nothing, sampled on CLOCK_50.
REQ-007 SHALL have port MODE, input, 2 bits: 0 pass, 1 hold, 2 rotate, 3 blink.
REQ-008 SHALL have port LOAD, input, 1 bit: level input; its 0->1 transition captures the pattern.
REQ-009 SHALL have port LEDR, output, WIDTH bits: registered LED drive.
REQ-010 SHALL have port TICK, output, 1 bit: one-clock pulse on each rotate/blink step.

Function
REQ-011 SHALL keep a debounced vector DB: per bit, a counter increments each clock SW[i] != DB[i] and clears when they are equal; when the counter would reach DB_CYCLES, DB[i] <= SW[i] and the counter clears.
REQ-012 SHALL ignore any SW bit glitch shorter than DB_CYCLES clocks (DB unchanged).
REQ-013 SHALL detect LOAD rising edge from a registered copy of LOAD (one edge-detect cycle); each edge sets PAT <= DB on that clock.
REQ-014 SHALL run a tick counter 0..TICK_CYCLES-1 in modes 2 and 3 only; TICK pulses high for the clock the counter wraps to 0; counter held at 0 and TICK low in modes 0 and 1.
REQ-015 Mode 0: LEDR <= DB each clock (total latency from a stable SW change to LEDR = DB_CYCLES+1 edges).
REQ-016 Mode 1: LEDR <= PAT each clock.
REQ-017 Mode 2: on each tick PAT rotates left by one (PAT[0] <= PAT[WIDTH-1]); LEDR <= PAT.
REQ-018 Mode 3: blink phase PH toggles on each tick; LEDR <= PH ? PAT : 0.
REQ-019 On any change of MODE: tick counter clears to 0, PH sets to 1, PAT unchanged; takes effect on the first clock the new MODE is sampled.
REQ-020 LOAD edge coinciding with a rotate tick: load wins; PAT <= DB, no rotation that cycle; tick counter still wraps.
REQ-021 All-zero or all-one PAT in mode 2 SHALL remain unchanged by rotation.
REQ-022 DB_CYCLES = 1 SHALL accept a change after one mismatched clock; counters sized ceil(log2(DB_CYCLES+1)) and ceil(log2(TICK_CYCLES)) bits, no overflow.

Reset
REQ-023 RST high SHALL immediately (no clock) force DB, PAT, LEDR, debounce counters, tick counter to 0, TICK to 0, PH to 1, registered LOAD to 0.
REQ-024 After RST falls, an already-high LOAD SHALL produce a load edge on the first clock; SW already high SHALL appear on DB after DB_CYCLES clocks.
REQ-025 RST asserted mid-rotate or mid-debounce SHALL discard all progress; no partial update survives.

Verification (WIDTH=10, DB_CYCLES=4, TICK_CYCLES=8)
REQ-026 Mode 0, SW 0 -> 10'b0101110101 held -> LEDR = 10'b0101110101 exactly 5 edges after the change, 0 before.
REQ-027 Mode 0, SW bit 0 pulsed high for 3 clocks -> LEDR stays 10'b0000000000.
REQ-028 Mode 1, SW=10'b0001000010 settled, LOAD 0->1, then SW=10'b1111111111 -> LEDR stays 10'b0001000010.
REQ-029 Mode 2 with PAT=10'b1000000000 -> TICK every 8 clocks, LEDR 10'b0000000001 after first tick, 10'b0000000010 after second; LOAD on a tick cycle with DB=10'b0010101110 -> LEDR 10'b0010101110, unrotated.
REQ-030 Mode 3 with PAT=10'b0110111010 -> LEDR alternates 10'b0110111010 / 0 every 8 clocks; switching to mode 2 mid-count -> tick counter restarts at 0.
REQ-031 RST asserted mid-rotation, between clock edges -> LEDR = 0 and TICK = 0 immediately; after release with LOAD held high -> PAT captured on the first clock.
